// File: rtl/kws_accel_pkg.sv
// Shared types and widths for the keyword-spotting MAC accelerator datapath.
package kws_accel_pkg;

  localparam int LANES  = 4;   // int8 lanes per 32-bit command word
  localparam int ACT_W  = 8;   // activation / filter element width
  localparam int OFF_W  = 9;   // signed input offset width
  localparam int OPND_W = 10;  // activation + offset, signed
  localparam int PROD_W = 18;  // per-lane signed product
  localparam int SUM_W  = 20;  // four-lane signed sum
  localparam int ACC_W  = 32;  // accumulator / dividend width
  localparam int EXP_W  = 4;   // per-channel exponent code

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'd0,
    OP_MAC4   = 2'd1,
    OP_FINISH = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_RESULT = 1'b1
  } state_e;

  // Sign-extend a four-lane sum onto the accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_sum(input logic signed [SUM_W-1:0] s);
    return ACC_W'(s);
  endfunction

endpackage

// File: rtl/kws_mac4.sv
// Combinational four-lane (act + offset) * filt dot product, 20-bit signed result.
module kws_mac4
  import kws_accel_pkg::*;
(
  input  logic [LANES*ACT_W-1:0] act_i,
  input  logic [LANES*ACT_W-1:0] filt_i,
  input  logic [OFF_W-1:0]       offset_i,
  output logic signed [SUM_W-1:0] sum_o
);

  logic signed [PROD_W-1:0] prod_s [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [OPND_W-1:0] opnd_s;
    logic signed [PROD_W-1:0] filt_s;

    // act in [-128,127] plus offset in [-256,255] always fits 10 bits signed
    assign opnd_s    = OPND_W'($signed(act_i[g*ACT_W +: ACT_W])) + OPND_W'($signed(offset_i));
    assign filt_s    = PROD_W'($signed(filt_i[g*ACT_W +: ACT_W]));
    assign prod_s[g] = PROD_W'(opnd_s) * filt_s;
  end

  // Sum the lane products; four 18-bit products cannot overflow 20 bits
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_o = sum_o + SUM_W'(prod_s[i]);
    end
  end

endmodule

// File: rtl/kws_mac_accum.sv
// Bias-initialised int32 MAC accumulator with a one-deep product pipeline and
// a valid/ready result port feeding the requantizer.
module kws_mac_accum
  import kws_accel_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [LANES*ACT_W-1:0] cmd_act,
  input  logic [LANES*ACT_W-1:0] cmd_filt,
  input  logic [OFF_W-1:0]       input_offset,
  input  logic [ACC_W-1:0]       cmd_bias,
  input  logic [EXP_W-1:0]       cmd_exponent,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ACC_W-1:0]       dividend,
  output logic [ACC_W-1:0]       exponent,
  output logic [CNT_W-1:0]       mac_count
);

  state_e                   state_q;
  logic                     cmd_ready_q;
  logic                     rsp_valid_q;
  logic signed [SUM_W-1:0]  p1_sum_q;
  logic                     p1_valid_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [EXP_W-1:0]         exp_q, exp_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  op_e                      op_s;
  logic                     accept_s;
  logic                     clear_s;
  logic signed [SUM_W-1:0]  mac_sum_s;

  assign op_s     = op_e'(cmd_op);
  // Commands are only offered while accumulating, so accept implies ST_ACCUM
  assign accept_s = cmd_valid && cmd_ready_q;
  assign clear_s  = accept_s && (op_s == OP_CLEAR);

  kws_mac4 u_mac4 (
    .act_i    (cmd_act),
    .filt_i   (cmd_filt),
    .offset_i (input_offset),
    .sum_o    (mac_sum_s)
  );

  // Accumulator next state: CLEAR wins and discards any in-flight product
  always_comb begin
    acc_d = acc_q;
    exp_d = exp_q;
    cnt_d = cnt_q;
    if (clear_s) begin
      acc_d = $signed(cmd_bias);
      exp_d = cmd_exponent;
      cnt_d = '0;
    end else if (p1_valid_q) begin
      acc_d = acc_q + sext_sum(p1_sum_q);
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Control FSM, product stage and accumulator registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ACCUM;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      p1_sum_q    <= '0;
      p1_valid_q  <= 1'b0;
      acc_q       <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
    end else begin
      acc_q <= acc_d;
      exp_q <= exp_d;
      cnt_q <= cnt_d;

      // Stage 1 only holds a product for the edge right after its MAC4
      p1_valid_q <= accept_s && (op_s == OP_MAC4);
      if (accept_s && (op_s == OP_MAC4)) begin
        p1_sum_q <= mac_sum_s;
      end else begin
        p1_sum_q <= p1_sum_q;
      end

      case (state_q)
        ST_ACCUM: begin
          if (accept_s && (op_s == OP_FINISH)) begin
            state_q     <= ST_RESULT;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b1;
          end else begin
            state_q     <= ST_ACCUM;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
          end
        end
        ST_RESULT: begin
          if (rsp_ready) begin
            state_q     <= ST_ACCUM;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
          end else begin
            state_q     <= ST_RESULT;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_ACCUM;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign dividend  = acc_q;
  assign exponent  = {{(ACC_W-EXP_W){1'b0}}, exp_q};
  assign mac_count = cnt_q;

endmodule

// File: tb/tb_kws_mac_accum.sv
// Directed self-checking bench for kws_mac_accum.
module tb_kws_mac_accum;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_act;
  logic [31:0] cmd_filt;
  logic [8:0]  input_offset;
  logic [31:0] cmd_bias;
  logic [3:0]  cmd_exponent;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] dividend;
  logic [31:0] exponent;
  logic [15:0] mac_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [1:0] C_CLEAR  = 2'd0;
  localparam logic [1:0] C_MAC4   = 2'd1;
  localparam logic [1:0] C_FINISH = 2'd2;
  localparam logic [1:0] C_RSVD   = 2'd3;

  kws_mac_accum #(.CNT_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_act      (cmd_act),
    .cmd_filt     (cmd_filt),
    .input_offset (input_offset),
    .cmd_bias     (cmd_bias),
    .cmd_exponent (cmd_exponent),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .dividend     (dividend),
    .exponent     (exponent),
    .mac_count    (mac_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One accepted command; called 1 time unit after a rising edge
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] act, input logic [31:0] filt,
                        input logic [31:0] bias, input logic [3:0] expo);
    cmd_op       = op;
    cmd_act      = act;
    cmd_filt     = filt;
    cmd_bias     = bias;
    cmd_exponent = expo;
    cmd_valid    = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
  endtask

  // Take the presented result with a one-cycle rsp_ready pulse
  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    total_cnt++;
    if (rsp_valid !== 1'b0 || dividend !== 32'd0 || exponent !== 32'd0 || mac_count !== 16'd0) begin
      $display("FAIL reset_outputs got v=%b d=%0d e=%0d c=%0d want 0/0/0/0", rsp_valid, dividend, exponent, mac_count);
    end else pass_cnt++;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    input_offset = 9'd128;
    do_cmd(C_CLEAR, 32'h0, 32'h0, 32'd100, 4'd3);
    do_cmd(C_MAC4, 32'h01010101, 32'h02020202, 32'd0, 4'd0);
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL basic_pre_finish_valid got %b want 0", rsp_valid);
    else pass_cnt++;
    do_cmd(C_FINISH, 32'h0, 32'h0, 32'd0, 4'd0);
    total_cnt++;
    if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL basic_rsp_valid got v=%b r=%b want 1/0", rsp_valid, cmd_ready);
    else pass_cnt++;
    total_cnt++;
    if (dividend !== 32'd1132) $display("FAIL basic_dividend got %0d want 1132", $signed(dividend));
    else pass_cnt++;
    total_cnt++;
    if (exponent !== 32'd3 || mac_count !== 16'd1) $display("FAIL basic_exp_count got e=%0d c=%0d want 3/1", exponent, mac_count);
    else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_sign();
    input_offset = 9'd128;
    do_cmd(C_CLEAR, 32'h0, 32'h0, 32'd0, 4'd0);
    do_cmd(C_MAC4, 32'h7F7F7F7F, 32'hFFFFFFFF, 32'd0, 4'd0);
    do_cmd(C_FINISH, 32'h0, 32'h0, 32'd0, 4'd0);
    total_cnt++;
    if ($signed(dividend) !== -32'sd1020) $display("FAIL sign_neg got %0d want -1020", $signed(dividend));
    else pass_cnt++;
    take_rsp();
    do_cmd(C_CLEAR, 32'h0, 32'h0, 32'd0, 4'd0);
    do_cmd(C_MAC4, 32'h80808080, 32'hFFFFFFFF, 32'd0, 4'd0);
    do_cmd(C_FINISH, 32'h0, 32'h0, 32'd0, 4'd0);
    total_cnt++;
    if (dividend !== 32'd0 || mac_count !== 16'd1) $display("FAIL sign_zero got d=%0d c=%0d want 0/1", $signed(dividend), mac_count);
    else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_back_to_back();
    int stalls;
    stalls = 0;
    input_offset = 9'd128;
    do_cmd(C_CLEAR, 32'h0, 32'h0, 32'd0, 4'd0);
    cmd_op    = C_MAC4;
    cmd_act   = 32'h7F7F7F7F;
    cmd_filt  = 32'h80808080;
    cmd_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (cmd_ready !== 1'b1) stalls++;
      @(posedge clk);
      #1;
    end
    cmd_op = C_FINISH;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    total_cnt++;
    if (stalls != 0) $display("FAIL b2b_stalls got %0d want 0", stalls);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 1'b1 || $signed(dividend) !== -32'sd33423360)
      $display("FAIL b2b_dividend got v=%b d=%0d want 1/-33423360", rsp_valid, $signed(dividend));
    else pass_cnt++;
    total_cnt++;
    if (mac_count !== 16'd256) $display("FAIL b2b_count got %0d want 256", mac_count);
    else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_backpressure();
    input_offset = 9'd128;
    do_cmd(C_CLEAR, 32'h0, 32'h0, 32'd100, 4'd3);
    do_cmd(C_MAC4, 32'h01010101, 32'h02020202, 32'd0, 4'd0);
    do_cmd(C_FINISH, 32'h0, 32'h0, 32'd0, 4'd0);
    // offer a CLEAR the whole time; it must be ignored
    cmd_op       = C_CLEAR;
    cmd_bias     = 32'd999;
    cmd_exponent = 4'd9;
    cmd_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total_cnt++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || dividend !== 32'd1132 || exponent !== 32'd3)
        $display("FAIL bp_hold_%0d got v=%b r=%b d=%0d e=%0d want 1/0/1132/3", i, rsp_valid, cmd_ready, $signed(dividend), exponent);
      else pass_cnt++;
    end
    cmd_valid = 1'b0;
    take_rsp();
    total_cnt++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || dividend !== 32'd1132 || mac_count !== 16'd1)
      $display("FAIL bp_release got v=%b r=%b d=%0d c=%0d want 0/1/1132/1", rsp_valid, cmd_ready, $signed(dividend), mac_count);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    input_offset = 9'd128;
    do_cmd(C_CLEAR, 32'h0, 32'h0, 32'd50, 4'd1);
    do_cmd(C_MAC4, 32'h01010101, 32'h02020202, 32'd0, 4'd0);
    do_cmd(C_CLEAR, 32'h0, 32'h0, 32'd7, 4'd2);
    do_cmd(C_FINISH, 32'h0, 32'h0, 32'd0, 4'd0);
    total_cnt++;
    if (dividend !== 32'd7 || mac_count !== 16'd0 || exponent !== 32'd2)
      $display("FAIL abort got d=%0d c=%0d e=%0d want 7/0/2", $signed(dividend), mac_count, exponent);
    else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_reserved_refinish();
    input_offset = 9'd128;
    do_cmd(C_CLEAR, 32'h0, 32'h0, 32'd0, 4'd1);
    do_cmd(C_MAC4, 32'h01010101, 32'h02020202, 32'd0, 4'd0);
    do_cmd(C_RSVD, 32'h01010101, 32'h02020202, 32'd0, 4'd0);
    do_cmd(C_FINISH, 32'h0, 32'h0, 32'd0, 4'd0);
    total_cnt++;
    if (dividend !== 32'd1032 || mac_count !== 16'd1)
      $display("FAIL rsvd got d=%0d c=%0d want 1032/1", $signed(dividend), mac_count);
    else pass_cnt++;
    take_rsp();
    do_cmd(C_FINISH, 32'h0, 32'h0, 32'd0, 4'd0);
    total_cnt++;
    if (rsp_valid !== 1'b1 || dividend !== 32'd1032 || mac_count !== 16'd1)
      $display("FAIL refinish got v=%b d=%0d c=%0d want 1/1032/1", rsp_valid, $signed(dividend), mac_count);
    else pass_cnt++;
    take_rsp();
  endtask

  task automatic test_reset_mid_op();
    input_offset = 9'd128;
    do_cmd(C_CLEAR, 32'h0, 32'h0, 32'd100, 4'd3);
    do_cmd(C_MAC4, 32'h01010101, 32'h02020202, 32'd0, 4'd0);
    do_cmd(C_FINISH, 32'h0, 32'h0, 32'd0, 4'd0);
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || dividend !== 32'd0 || exponent !== 32'd0 || mac_count !== 16'd0)
      $display("FAIL rst_async got v=%b d=%0d e=%0d c=%0d want 0/0/0/0", rsp_valid, $signed(dividend), exponent, mac_count);
    else pass_cnt++;
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rst_release got r=%b v=%b want 1/0", cmd_ready, rsp_valid);
    else pass_cnt++;
    // lanes: 3*1 + 2*2 + (-1)*3 + 1*5 = 9 per MAC4, offset 0
    input_offset = 9'd0;
    do_cmd(C_CLEAR, 32'h0, 32'h0, 32'hFFFFFFFB, 4'd15);
    do_cmd(C_MAC4, 32'h01FF0203, 32'h05030201, 32'd0, 4'd0);
    do_cmd(C_MAC4, 32'h01FF0203, 32'h05030201, 32'd0, 4'd0);
    do_cmd(C_FINISH, 32'h0, 32'h0, 32'd0, 4'd0);
    total_cnt++;
    if (rsp_valid !== 1'b1 || dividend !== 32'd13 || exponent !== 32'd15 || mac_count !== 16'd2)
      $display("FAIL rst_resume got v=%b d=%0d e=%0d c=%0d want 1/13/15/2", rsp_valid, $signed(dividend), exponent, mac_count);
    else pass_cnt++;
    take_rsp();
  endtask

  initial begin
    cmd_valid    = 1'b0;
    cmd_op       = 2'd0;
    cmd_act      = 32'd0;
    cmd_filt     = 32'd0;
    input_offset = 9'd0;
    cmd_bias     = 32'd0;
    cmd_exponent = 4'd0;
    rsp_ready    = 1'b0;
    test_reset();
    test_basic();
    test_sign();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reserved_refinish();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
